// File: rtl/twos_comp_serial.sv
// Bit-serial two's-complement negate / absolute-value unit.
// Operand is consumed LSB-first with the copy-through-first-1-then-invert rule.
module twos_comp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] comp,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] comp_reg;
  logic [CNT_W-1:0] cnt;
  logic             seen_one;
  logic             invert_en;
  logic             ovf_reg;
  logic             capture_inv;
  logic             bit_out;

  // Abs mode only inverts negative operands; negate mode always does.
  assign capture_inv = ~mode | a[WIDTH-1];
  assign bit_out     = (invert_en & seen_one) ? ~shift_reg[0] : shift_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      comp_reg  <= '0;
      cnt       <= '0;
      seen_one  <= 1'b0;
      invert_en <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= a;
            invert_en <= capture_inv;
            ovf_reg   <= capture_inv && (a == MOST_NEG);
            cnt       <= '0;
            seen_one  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
          comp_reg  <= {bit_out, comp_reg[WIDTH-1:1]};
          shift_reg <= shift_reg >> 1;
          seen_one  <= seen_one | shift_reg[0];
          cnt       <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign comp      = comp_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_twos_comp_serial.sv
// Directed bench for twos_comp_serial: a WIDTH=4 instance for the corner cases
// and a WIDTH=8 instance for the exhaustive sweep, both checked every cycle.
module tb_twos_comp_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic       in_valid4 = 1'b0, mode4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0] a4 = '0;
  logic       in_ready4, out_valid4, ovf4, busy4;
  logic [3:0] comp4;

  logic       in_valid8 = 1'b0, mode8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0;
  logic       in_ready8, out_valid8, ovf8, busy8;
  logic [7:0] comp8;

  twos_comp_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .mode(mode4),
    .a(a4), .out_valid(out_valid4), .out_ready(out_ready4), .comp(comp4),
    .ovf(ovf4), .busy(busy4)
  );

  twos_comp_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .mode(mode8),
    .a(a8), .out_valid(out_valid8), .out_ready(out_ready8), .comp(comp8),
    .ovf(ovf8), .busy(busy8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain signed arithmetic on the operand.
  function automatic int ref_comp(int w, int av, bit m);
    int sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    int r  = (!m || sa < 0) ? -sa : sa;
    return r & ((1 << w) - 1);
  endfunction

  function automatic bit ref_ovf(int w, int av, bit m);
    int sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    return (!m || sa < 0) && (av == (1 << (w - 1)));
  endfunction

  // Per-instance model: one outstanding operand, result due WIDTH edges after accept.
  bit pend4 = 0, e_ovf4 = 0;
  int acc4 = 0, e_comp4 = 0;
  always @(negedge clk) begin
    bit exp_ov;
    if (rst) begin
      chk("rst4_in_ready", in_ready4, 1);
      chk("rst4_out_valid", out_valid4, 0);
      chk("rst4_busy", busy4, 0);
      chk("rst4_comp", comp4, 0);
      chk("rst4_ovf", ovf4, 0);
      pend4 = 0;
    end else begin
      exp_ov = pend4 && (cyc >= acc4 + 4);
      chk("w4_in_ready", in_ready4, !pend4);
      chk("w4_busy", busy4, pend4);
      chk("w4_out_valid", out_valid4, exp_ov);
      if (exp_ov && out_valid4) begin
        chk("w4_comp", comp4, e_comp4);
        chk("w4_ovf", ovf4, e_ovf4);
      end
      if (!pend4) begin
        if (in_valid4) begin
          pend4 = 1; acc4 = cyc + 1;
          e_comp4 = ref_comp(4, int'(a4), mode4);
          e_ovf4  = ref_ovf(4, int'(a4), mode4);
        end
      end else if (exp_ov && out_ready4) begin
        pend4 = 0;
      end
    end
  end

  bit pend8 = 0, e_ovf8 = 0;
  int acc8 = 0, e_comp8 = 0;
  always @(negedge clk) begin
    bit exp_ov;
    if (rst) begin
      chk("rst8_in_ready", in_ready8, 1);
      chk("rst8_out_valid", out_valid8, 0);
      chk("rst8_comp", comp8, 0);
      pend8 = 0;
    end else begin
      exp_ov = pend8 && (cyc >= acc8 + 8);
      chk("w8_in_ready", in_ready8, !pend8);
      chk("w8_busy", busy8, pend8);
      chk("w8_out_valid", out_valid8, exp_ov);
      if (exp_ov && out_valid8) begin
        chk("w8_comp", comp8, e_comp8);
        chk("w8_ovf", ovf8, e_ovf8);
      end
      if (!pend8) begin
        if (in_valid8) begin
          pend8 = 1; acc8 = cyc + 1;
          e_comp8 = ref_comp(8, int'(a8), mode8);
          e_ovf8  = ref_ovf(8, int'(a8), mode8);
        end
      end else if (exp_ov && out_ready8) begin
        pend8 = 0;
      end
    end
  end

  function automatic bit rdy(int w);
    return (w == 4) ? in_ready4 : in_ready8;
  endfunction

  function automatic bit ovld(int w);
    return (w == 4) ? out_valid4 : out_valid8;
  endfunction

  // One transaction with out_ready held high; result sampled 1 time unit after its edge.
  task automatic run(input int w, input int av, input bit m, output int c, output bit o);
    int t0;
    int i;
    @(posedge clk); #1;
    if (w == 4) begin a4 = av[3:0]; mode4 = m; in_valid4 = 1; out_ready4 = 1; end
    else        begin a8 = av[7:0]; mode8 = m; in_valid8 = 1; out_ready8 = 1; end
    i = 0;
    while (!rdy(w) && i < 20) begin @(posedge clk); #1; i++; end
    @(posedge clk); #1;
    t0 = cyc;
    in_valid4 = 0; in_valid8 = 0;
    i = 0;
    while (!ovld(w) && i < 40) begin @(posedge clk); #1; i++; end
    if (!ovld(w)) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: w=%0d a=%0h out_valid never rose", w, av);
      c = -1; o = 0;
    end else begin
      c = (w == 4) ? int'(comp4) : int'(comp8);
      o = (w == 4) ? ovf4 : ovf8;
      chk("latency", cyc - t0, w);
    end
    $display("w=%0d mode=%0d a=%0h -> comp=%0h ovf=%0d", w, m, av, c, o);
  endtask

  task automatic wait_valid4();
    int i = 0;
    while (!out_valid4 && i < 40) begin @(posedge clk); #1; i++; end
    if (!out_valid4) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: w=4 out_valid never rose");
    end
  endtask

  initial begin
    int c;
    bit o;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready4, 1);
    chk("reset_comp", comp4, 0);
    rst = 0;

    run(4, 4'b0011, 0, c, o);
    chk("neg_0011_comp", c, 4'b1101);
    chk("neg_0011_ovf", o, 0);
    @(posedge clk); #1;
    chk("neg_0011_ready_back", in_ready4, 1);

    run(4, 4'b0000, 0, c, o);
    chk("neg_0000_comp", c, 4'b0000);
    chk("neg_0000_ovf", o, 0);
    run(4, 4'b1000, 0, c, o);
    chk("neg_1000_comp", c, 4'b1000);
    chk("neg_1000_ovf", o, 1);
    run(4, 4'b1010, 1, c, o);
    chk("abs_1010_comp", c, 4'b0110);
    chk("abs_1010_ovf", o, 0);
    run(4, 4'b0101, 1, c, o);
    chk("abs_0101_comp", c, 4'b0101);
    chk("abs_0101_ovf", o, 0);

    // Backpressure with a second operand knocking during DONE.
    @(posedge clk); #1;
    a4 = 4'b0111; mode4 = 0; in_valid4 = 1; out_ready4 = 0;
    @(posedge clk); #1;
    in_valid4 = 0;
    wait_valid4();
    a4 = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      chk("bp_comp_held", comp4, 4'b1001);
      chk("bp_valid_held", out_valid4, 1);
      in_valid4 = ~in_valid4;
      @(posedge clk); #1;
    end
    in_valid4 = 1; out_ready4 = 1;
    @(posedge clk); #1;
    chk("bp_not_taken_on_retire", busy4, 0);
    @(posedge clk); #1;
    in_valid4 = 0;
    chk("bp_taken_next", busy4, 1);
    wait_valid4();
    chk("bp_second_comp", comp4, 4'b1111);
    $display("w=4 mode=0 a=1 -> comp=%0h ovf=%0d (after backpressure)", comp4, ovf4);

    // Reset two cycles into SHIFT.
    @(posedge clk); #1;
    a4 = 4'b0101; mode4 = 0; in_valid4 = 1;
    @(posedge clk); #1;
    in_valid4 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midrst_in_ready", in_ready4, 1);
    chk("midrst_out_valid", out_valid4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_comp", comp4, 0);
    @(posedge clk); #1;
    rst = 0;
    run(4, 4'b0110, 0, c, o);
    chk("post_rst_neg_0110", c, 4'b1010);

    run(8, 8'h80, 1, c, o);
    chk("abs_80_comp", c, 8'h80);
    chk("abs_80_ovf", o, 1);
    run(8, 8'hFF, 1, c, o);
    chk("abs_FF_comp", c, 8'h01);

    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        run(8, v, m[0], c, o);
        chk("sweep_ovf", o, (v == 8'h80));
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
